// File: rtl/task_trace_logger.sv
// Scheduler trace logger: run-length encodes the running task id into
// {id, start_cycle, run_len} records and buffers them in a small FIFO.
// Optional build macro TRACE_IDLE_EN also logs idle stretches as records.
module task_trace_logger #(
  parameter int          FIFO_DEPTH = 8,
  parameter logic [15:0] IDLE_ID    = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] task_id,
  input  logic        flush,
  input  logic        rec_ready,
  output logic        rec_valid,
  output logic [31:0] rec_data,
  output logic        ovf,
  output logic [7:0]  drop_cnt,
  output logic [15:0] switch_cnt
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  typedef enum logic {S_IDLE, S_TRACK} state_t;

  state_t      state_reg, state_next;
  logic [15:0] cur_id_reg, cur_id_next;
  logic [7:0]  start_reg, start_next;
  logic [7:0]  len_reg, len_next;
  logic [7:0]  cyc_reg;

  logic        loggable;
  logic        push_req;
  logic [31:0] push_data;
  logic        switch_inc;

`ifdef TRACE_IDLE_EN
  assign loggable = 1'b1;
`else
  assign loggable = (task_id != IDLE_ID);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= S_IDLE;
      cur_id_reg <= 16'd0;
      start_reg  <= 8'd0;
      len_reg    <= 8'd0;
      cyc_reg    <= 8'd0;
    end else begin
      state_reg  <= state_next;
      cur_id_reg <= cur_id_next;
      start_reg  <= start_next;
      len_reg    <= len_next;
      cyc_reg    <= cyc_reg + 8'd1;
    end
  end

  always_comb begin
    state_next  = state_reg;
    cur_id_next = cur_id_reg;
    start_next  = start_reg;
    len_next    = len_reg;
    push_req    = 1'b0;
    push_data   = {cur_id_reg, start_reg, len_reg};
    switch_inc  = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (loggable) begin
          state_next  = S_TRACK;
          cur_id_next = task_id;
          start_next  = cyc_reg;
          len_next    = 8'd1;
        end
      end
      S_TRACK: begin
        if (flush) begin
          push_req   = 1'b1;
          state_next = S_IDLE;
        end else if (task_id == cur_id_reg && len_reg != 8'hFF) begin
          len_next = len_reg + 8'd1;
        end else begin
          // Either a different id or a saturated run: close and maybe reopen.
          push_req = 1'b1;
          if (loggable) begin
            cur_id_next = task_id;
            start_next  = cyc_reg;
            len_next    = 8'd1;
            switch_inc  = (task_id != cur_id_reg) && (cur_id_reg != IDLE_ID)
                          && (task_id != IDLE_ID);
          end else begin
            state_next = S_IDLE;
          end
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [CW-1:0] count_reg, count_next;
  logic          rec_valid_reg;
  logic [31:0]   rec_data_reg;
  logic          ovf_reg;
  logic [7:0]    drop_cnt_reg;
  logic [15:0]   switch_cnt_reg;
  logic          pop, full, push_ok, drop;

  assign pop     = rec_valid_reg && rec_ready;
  assign full    = (count_reg == DEPTH_C);
  assign push_ok = push_req && (!full || pop);
  assign drop    = push_req && !push_ok;

  always_comb begin
    count_next  = count_reg;
    rd_ptr_next = rd_ptr_reg;
    if (push_ok && !pop)
      count_next = count_reg + CW'(1);
    else if (!push_ok && pop)
      count_next = count_reg - CW'(1);
    if (pop)
      rd_ptr_next = rd_ptr_reg + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst && push_ok)
      mem[wr_ptr_reg] <= push_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      rec_valid_reg  <= 1'b0;
      rec_data_reg   <= 32'd0;
      ovf_reg        <= 1'b0;
      drop_cnt_reg   <= 8'd0;
      switch_cnt_reg <= 16'd0;
    end else begin
      if (push_ok)
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      rec_valid_reg <= (count_next != '0);
      // Head register: bypass the record being written when it becomes the head.
      if (count_next != '0)
        rec_data_reg <= (push_ok && wr_ptr_reg == rd_ptr_next) ? push_data
                                                               : mem[rd_ptr_next];
      if (drop) begin
        ovf_reg <= 1'b1;
        if (drop_cnt_reg != 8'hFF)
          drop_cnt_reg <= drop_cnt_reg + 8'd1;
      end
      if (switch_inc)
        switch_cnt_reg <= switch_cnt_reg + 16'd1;
    end
  end

  assign rec_valid  = rec_valid_reg;
  assign rec_data   = rec_data_reg;
  assign ovf        = ovf_reg;
  assign drop_cnt   = drop_cnt_reg;
  assign switch_cnt = switch_cnt_reg;

endmodule

// File: tb/tb_task_trace_logger.sv
// Randomised and directed bench for task_trace_logger with a queue scoreboard
// fed by a behavioural run-length/FIFO model.
module tb_task_trace_logger;
  localparam int          DEPTH = 8;
  localparam logic [15:0] IDLE  = 16'hFFFF;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] task_id = IDLE;
  logic        flush = 1'b0;
  logic        rec_ready = 1'b0;
  logic        rec_valid;
  logic [31:0] rec_data;
  logic        ovf;
  logic [7:0]  drop_cnt;
  logic [15:0] switch_cnt;

  task_trace_logger #(.FIFO_DEPTH(DEPTH), .IDLE_ID(IDLE)) dut (
    .clk(clk), .rst(rst), .task_id(task_id), .flush(flush),
    .rec_ready(rec_ready), .rec_valid(rec_valid), .rec_data(rec_data),
    .ovf(ovf), .drop_cnt(drop_cnt), .switch_cnt(switch_cnt)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model state: the open run and the record buffer contents.
  logic [31:0] exp_q[$];
  logic [31:0] got_log[$];
  int          occ = 0;
  bit          seg_open = 0;
  logic [15:0] seg_id = 0;
  logic [7:0]  seg_start = 0;
  int          seg_len = 0;
  logic [7:0]  m_cyc = 0;
  bit          m_ovf = 0;
  int          m_drop = 0;
  logic [15:0] m_sw = 0;

  // Values the DUT should present during the current cycle.
  bit          started = 0;
  bit          skip = 1;
  bit          vis_valid = 0;
  bit          vis_ovf = 0;
  int          vis_drop = 0;
  logic [15:0] vis_sw = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  function automatic logic [31:0] logged(input int i);
    if (i < got_log.size()) return got_log[i];
    return 32'hDEAD_BEEF;
  endfunction

  function automatic bit is_loggable(input logic [15:0] id);
`ifdef TRACE_IDLE_EN
    return 1'b1;
`else
    return id != IDLE;
`endif
  endfunction

  task automatic step(input bit r, input logic [15:0] id, input bit f, input bit rdy);
    bit          has_push;
    bit          pop_now;
    logic [31:0] rec;
    @(posedge clk);
    #1;
    rst = r; task_id = id; flush = f; rec_ready = rdy;
    skip      = r;
    vis_valid = (occ > 0);
    vis_ovf   = m_ovf;
    vis_drop  = m_drop;
    vis_sw    = m_sw;
    if (r) begin
      exp_q.delete();
      occ = 0; seg_open = 0; m_cyc = 0; m_ovf = 0; m_drop = 0; m_sw = 0;
      return;
    end
    started  = 1;
    has_push = 0;
    rec      = {seg_id, seg_start, 8'(seg_len)};
    if (!seg_open) begin
      if (is_loggable(id)) begin
        seg_open = 1; seg_id = id; seg_start = m_cyc; seg_len = 1;
      end
    end else if (f) begin
      has_push = 1; seg_open = 0;
    end else if (id == seg_id && seg_len < 255) begin
      seg_len++;
    end else begin
      has_push = 1;
      if (seg_id != IDLE && id != IDLE && id != seg_id) m_sw++;
      if (is_loggable(id)) begin
        seg_id = id; seg_start = m_cyc; seg_len = 1;
      end else seg_open = 0;
    end
    pop_now = (occ > 0) && rdy;
    if (has_push) begin
      if (occ == DEPTH && !pop_now) begin
        m_ovf = 1;
        if (m_drop < 255) m_drop++;
      end else begin
        exp_q.push_back(rec);
        occ++;
      end
    end
    if (pop_now) occ--;
    m_cyc++;
  endtask

  // Monitor: outputs are stable at the falling edge; a handshake here pops next edge.
  always @(negedge clk) begin
    if (started && !skip) begin
      chk("rec_valid", {31'd0, rec_valid}, {31'd0, vis_valid});
      if (rec_valid === 1'b1) begin
        if (exp_q.size() == 0) chk("rec_data_unexpected", rec_data, 32'hDEAD_BEEF);
        else begin
          chk("rec_data", rec_data, exp_q[0]);
          if (rec_ready) begin
            void'(exp_q.pop_front());
            got_log.push_back(rec_data);
          end
        end
      end
      chk("ovf", {31'd0, ovf}, {31'd0, vis_ovf});
      chk("drop_cnt", {24'd0, drop_cnt}, 32'(vis_drop));
      chk("switch_cnt", {16'd0, switch_cnt}, {16'd0, vis_sw});
    end
  end

  task automatic do_reset();
    step(1, IDLE, 0, 0);
    step(1, IDLE, 0, 0);
    got_log.delete();
  endtask

  initial begin
    // Two short runs with a switch.
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 16'd5, 0, 1);
    for (int i = 0; i < 2; i++) step(0, 16'd3, 0, 1);
    for (int i = 0; i < 5; i++) step(0, IDLE, 0, 1);
    chk("basic_count", 32'(got_log.size()), 32'd2);
    chk("basic_rec0", logged(0), 32'h0005_0003);
    chk("basic_rec1", logged(1), 32'h0003_0302);
    chk("basic_switch", {16'd0, switch_cnt}, 32'd1);

    // Saturating run length splits a long run.
    do_reset();
    for (int i = 0; i < 300; i++) step(0, 16'd7, 0, 1);
    for (int i = 0; i < 3; i++) step(0, IDLE, 0, 1);
    chk("sat_rec0", logged(0), 32'h0007_00FF);
    chk("sat_rec1", logged(1), 32'h0007_FF2D);
    chk("sat_switch", {16'd0, switch_cnt}, 32'd0);

    // Overflow with a stalled consumer.
    do_reset();
    for (int i = 0; i < 10; i++) step(0, (i % 2 == 0) ? 16'd1 : 16'd2, 0, 0);
    for (int i = 0; i < 2; i++) step(0, IDLE, 0, 0);
    chk("ovf_flag", {31'd0, ovf}, 32'd1);
    chk("ovf_drops", {24'd0, drop_cnt}, 32'd2);
    chk("ovf_valid", {31'd0, rec_valid}, 32'd1);
    chk("ovf_head", rec_data, 32'h0001_0001);
    for (int i = 0; i < 12; i++) step(0, IDLE, 0, 1);
    chk("ovf_drained", 32'(got_log.size()), 32'd8);

    // Flush closes the open run; the next cycle reopens.
    do_reset();
    for (int i = 0; i < 4; i++) step(0, 16'd9, 0, 1);
    step(0, 16'd9, 1, 1);
    step(0, 16'd9, 0, 1);
    for (int i = 0; i < 3; i++) step(0, IDLE, 0, 1);
    chk("flush_rec0", logged(0), 32'h0009_0004);
    chk("flush_rec1", logged(1), 32'h0009_0501);

`ifdef TRACE_IDLE_EN
    do_reset();
    for (int i = 0; i < 2; i++) step(0, IDLE, 0, 1);
    for (int i = 0; i < 2; i++) step(0, 16'd4, 0, 1);
    step(0, 16'd4, 1, 1);
    for (int i = 0; i < 3; i++) step(0, 16'd4, 1, 1);
    chk("idle_rec0", logged(0), 32'hFFFF_0002);
    chk("idle_switch", {16'd0, switch_cnt}, 32'd0);
`endif

    // Reset in the middle of a run with records buffered.
    do_reset();
    for (int i = 1; i <= 4; i++) step(0, 16'(i), 0, 0);
    step(0, 16'd4, 0, 0);
    chk("mid_buffered", {31'd0, rec_valid}, 32'd1);
    step(1, 16'd4, 0, 1);
    step(0, IDLE, 0, 1);
    chk("mid_valid", {31'd0, rec_valid}, 32'd0);
    chk("mid_switch", {16'd0, switch_cnt}, 32'd0);
    chk("mid_drop", {24'd0, drop_cnt}, 32'd0);
    for (int i = 0; i < 5; i++) step(0, IDLE, 0, 1);
    chk("mid_no_records", 32'(got_log.size()), 32'd0);

    // Random runs, flushes, stalls and rare resets.
    do_reset();
    for (int n = 0; n < 600; n++) begin
      int          run;
      logic [15:0] id;
      case ($urandom_range(0, 4))
        0: id = IDLE;
        1: id = 16'd1;
        2: id = 16'd2;
        default: id = 16'($urandom_range(3, 6));
      endcase
      run = ($urandom_range(0, 40) == 0) ? $urandom_range(250, 300) : $urandom_range(1, 6);
      for (int k = 0; k < run; k++)
        step($urandom_range(0, 400) == 0, id, $urandom_range(0, 19) == 0,
             $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 20; i++) step(0, IDLE, 0, 1);
    chk("final_empty", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
